// File: rtl/lsu_defs.sv
// rtl/lsu_defs.sv - shared funct3, cause and state definitions for the load/store unit
package lsu_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Illegal encodings win over misalignment; funct3[1:0] gives the access size.
  function automatic cause_e classify(
    input logic       i_load,
    input logic       i_store,
    input logic [2:0] i_funct3,
    input logic [1:0] i_addr_lo
  );
    logic w_illegal;
    logic w_misaligned;
    w_illegal = (i_load && i_store) ||
                (i_load && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)) ||
                (i_store && (i_funct3 >= 3'b011));
    w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    if (w_illegal) begin
      return CAUSE_ILLEGAL;
    end
    if (w_misaligned) begin
      return CAUSE_MISALIGN;
    end
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-enable/replication and load lane extraction
module lsu_align
  import lsu_defs::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_rdata = w_lane;
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_LH:   o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_LBU:  o_rdata = {24'h0, w_lane[7:0]};
      F3_LHU:  o_rdata = {16'h0, w_lane[15:0]};
      default: o_rdata = w_lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit bridging the MEM phase to a req/ack data bus
module load_store_unit
  import lsu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        stall_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // The counter only has to reach TIMEOUT_CYCLES-1; the ack-less cycle after that times out.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           r_state;
  logic [1:0]       r_addr_lo;
  logic [2:0]       r_funct3;
  logic             r_we;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_rdata;
  logic             r_rdata_valid;
  logic             r_exc;
  cause_e           r_exc_cause;

  logic             w_access;
  logic             w_in_req;
  logic             w_timeout;
  cause_e           w_cause;
  logic [2:0]       w_align_funct3;
  logic [1:0]       w_align_addr_lo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_fmt;
  logic [31:0]      w_rdata_ext;

  assign w_access  = load_i | store_i;
  assign w_in_req  = (r_state == ST_REQ);
  assign w_cause   = classify(load_i, store_i, funct3_i, addr_i[1:0]);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == LAST_WAIT);

  // Store formatting uses the live request; load extraction uses the latched one.
  assign w_align_funct3  = w_in_req ? r_funct3  : funct3_i;
  assign w_align_addr_lo = w_in_req ? r_addr_lo : addr_i[1:0];

  lsu_align u_align (
    .i_funct3  (w_align_funct3),
    .i_addr_lo (w_align_addr_lo),
    .i_wdata   (wdata_i),
    .i_rdata   (mem_rdata_i),
    .o_be      (w_be),
    .o_wdata   (w_wdata_fmt),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr_lo     <= 2'b00;
      r_funct3      <= 3'b000;
      r_we          <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_be      <= 4'b0000;
      r_mem_wdata   <= 32'h0;
      r_rdata       <= 32'h0;
      r_rdata_valid <= 1'b0;
      r_exc         <= 1'b0;
      r_exc_cause   <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_cause != CAUSE_NONE) begin
              r_exc       <= 1'b1;
              r_exc_cause <= w_cause;
              r_state     <= ST_DONE;
            end else begin
              r_addr_lo   <= addr_i[1:0];
              r_funct3    <= funct3_i;
              r_we        <= store_i;
              r_wait_cnt  <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= store_i;
              r_mem_addr  <= {addr_i[31:2], 2'b00};
              r_mem_be    <= store_i ? w_be : 4'b0000;
              r_mem_wdata <= store_i ? w_wdata_fmt : 32'h0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= 4'b0000;
            if (!r_we) begin
              r_rdata       <= w_rdata_ext;
              r_rdata_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_exc       <= 1'b1;
            r_exc_cause <= CAUSE_TIMEOUT;
            r_state     <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // The pipeline still shows the finished instruction here, so inputs are ignored.
          r_rdata_valid <= 1'b0;
          r_exc         <= 1'b0;
          r_exc_cause   <= CAUSE_NONE;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_o       = ((r_state == ST_IDLE) && w_access) || w_in_req;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdata_valid;
  assign exc_o         = r_exc;
  assign exc_cause_o   = r_exc_cause;
  assign mem_req_o     = r_mem_req;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_mem_addr;
  assign mem_be_o      = r_mem_be;
  assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, stall_o, exc_o;
  logic [1:0]  exc_cause_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .stall_o(stall_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [1:0] m_cause(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    if (ld && st) return 2'd2;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 2'd2;
    if (st && f3 >= 3) return 2'd2;
    bytes = 1 << (int'(f3) % 4);
    if ((int'(a[1:0]) % bytes) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    bytes = 1 << (int'(f3) % 4);
    return 4'(((1 << bytes) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] lane;
    logic [31:0] v;
    lane = rd >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = lane & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = lane & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = lane & 32'hFF;
      3'd5: v = lane & 32'hFFFF;
      default: v = lane;
    endcase
    return v;
  endfunction

  task automatic run_access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int delay, input bit keep);
    logic [1:0] ec, exp_cause;
    int stalls, reqs, exp_stalls, exp_reqs, cyc;
    bit done, exp_valid;
    ec = m_cause(ld, st, f3, a);
    if (ec != 0) begin
      exp_reqs = 0; exp_stalls = 1; exp_cause = ec;
    end else if (delay + 1 > TO) begin
      exp_reqs = TO; exp_stalls = TO + 1; exp_cause = 2'd3;
    end else begin
      exp_reqs = delay + 1; exp_stalls = delay + 2; exp_cause = 2'd0;
    end
    exp_valid = ld && !st && (exp_cause == 0);
    @(negedge clk);
    load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    mem_rdata_i = rd; mem_ack_i = 1'b0;
    #1;
    stalls = 0; reqs = 0; done = 0; cyc = 0;
    while (!done) begin
      if (stall_o) begin
        stalls++;
        if (mem_req_o) begin
          reqs++;
          n_tests++;
          if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !==
              {st, a & ~32'h3, st ? m_be(f3, a) : 4'b0000, st ? m_wdata(f3, wd) : 32'h0}) begin
            n_fail++;
            $display("FAIL bus_fields a=%h: got we=%b addr=%h be=%b wd=%h, want we=%b addr=%h be=%b wd=%h",
                     a, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, st, a & ~32'h3,
                     st ? m_be(f3, a) : 4'b0000, st ? m_wdata(f3, wd) : 32'h0);
          end
          mem_ack_i = (reqs == delay + 1);
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        done = 1;
        mem_ack_i = 1'b0;
        if (exp_valid) last_load = m_rdata(f3, a, rd);
        n_tests++;
        if ({exc_o, exc_cause_o, rdata_valid_o, mem_req_o} !== {exp_cause != 0, exp_cause, exp_valid, 1'b0}) begin
          n_fail++;
          $display("FAIL done_flags a=%h f3=%0d: got exc=%b cause=%0d valid=%b req=%b, want exc=%b cause=%0d valid=%b req=0",
                   a, f3, exc_o, exc_cause_o, rdata_valid_o, mem_req_o, exp_cause != 0, exp_cause, exp_valid);
        end
        n_tests++;
        if (rdata_o !== last_load) begin
          n_fail++;
          $display("FAIL rdata a=%h f3=%0d: got %h want %h", a, f3, rdata_o, last_load);
        end
        n_tests++;
        if (stalls != exp_stalls || reqs != exp_reqs) begin
          n_fail++;
          $display("FAIL cycle_counts a=%h: got stall=%0d req=%0d want stall=%0d req=%0d",
                   a, stalls, reqs, exp_stalls, exp_reqs);
        end
      end
      if (!done) begin
        cyc++;
        if (cyc > 50) begin
          n_tests++; n_fail++;
          $display("FAIL done_timeout a=%h: got no DONE within 50 cycles want DONE", a);
          done = 1;
        end else begin
          @(negedge clk); #1;
        end
      end
    end
    if (!keep) begin
      load_i = 1'b0; store_i = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if ({stall_o, exc_o, rdata_valid_o, mem_req_o} !== 4'b0000) begin
        n_fail++;
        $display("FAIL after_done: got stall=%b exc=%b valid=%b req=%b want all 0",
                 stall_o, exc_o, rdata_valid_o, mem_req_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_i = 1'b0; store_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_tests++;
    if ({rdata_o, rdata_valid_o, stall_o, exc_o, exc_cause_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h req=%b addr=%h be=%b wd=%h want all 0",
               rdata_o, mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    rst = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if ({stall_o, exc_o, rdata_valid_o, mem_req_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stray_ack: got stall=%b exc=%b valid=%b req=%b want all 0",
               stall_o, exc_o, rdata_valid_o, mem_req_o);
    end
    mem_ack_i = 1'b0;
  endtask

  task automatic test_store_sb();
    run_access(0, 1, 3'b000, 32'h00001003, 32'h000000A5, 32'h0, 0, 0);
    run_access(0, 1, 3'b001, 32'h00001002, 32'h1234BEEF, 32'h0, 1, 0);
    run_access(0, 1, 3'b010, 32'h00001004, 32'hCAFEF00D, 32'h0, 0, 0);
  endtask

  task automatic test_load_ext();
    run_access(1, 0, 3'b000, 32'h00002002, 32'h0, 32'h00800000, 0, 0);
    run_access(1, 0, 3'b100, 32'h00002002, 32'h0, 32'h00800000, 0, 0);
    run_access(1, 0, 3'b001, 32'h00002002, 32'h0, 32'h80010000, 0, 0);
  endtask

  task automatic test_wait_states();
    run_access(1, 0, 3'b010, 32'h00002008, 32'h0, 32'hDEADBEEF, 3, 0);
  endtask

  task automatic test_exceptions();
    run_access(1, 0, 3'b010, 32'h00003002, 32'h0, 32'h0, 0, 0);
    run_access(0, 1, 3'b011, 32'h00003000, 32'h0, 32'h0, 0, 0);
    run_access(1, 1, 3'b010, 32'h00003000, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h00005000, 32'h0, 32'h11111111, 99, 0);
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h00004000; mem_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL req_before_reset: got req=%b want 1", mem_req_o);
    end
    rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF; load_i = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({rdata_o, rdata_valid_o, stall_o, exc_o, exc_cause_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_req: got rdata=%h valid=%b req=%b addr=%h want all 0",
               rdata_o, rdata_valid_o, mem_req_o, mem_addr_o);
    end
    rst = 1'b0; mem_ack_i = 1'b0;
    last_load = 32'h0;
    run_access(1, 0, 3'b010, 32'h00004000, 32'h0, 32'h76543210, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_access(0, 1, 3'b010, 32'h00006000, 32'h01020304, 32'h0, 0, 1);
    run_access(0, 1, 3'b010, 32'h00006000, 32'h01020304, 32'h0, 0, 1);
    run_access(1, 0, 3'b101, 32'h00006002, 32'h0, 32'hF00F1234, 2, 0);
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      int r;
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      ld = (r < 4) || (r >= 8);
      st = (r >= 4);
      if ($urandom_range(0, 3) != 0) f3 = st && !ld ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
      run_access(ld, st, f3, a, $urandom, $urandom, int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_sb();
    test_load_ext();
    test_wait_states();
    test_exceptions();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
